// File: rtl/sim_check_sequencer_pkg.sv
// rtl/sim_check_sequencer_pkg.sv - shared types and helpers for the check sequencer
// Package sim_check_pkg: sequencer state and result encodings, counter widths,
// and the fail_chan width helper. No ports.
package sim_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } result_e;

  // Tallies and the drain counter only need to reach 255.
  localparam int TALLY_W = 8;
  localparam int DRAIN_W = 8;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int fail_chan_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sim_check_sequencer_if.sv
// rtl/sim_check_sequencer_if.sv - handshake bundle between tester logic and the sequencer
// Signals: start, chk_valid/chk_pass (tester -> sequencer);
// busy, done, pass, timeout, fail_valid, fail_chan, cycle_cnt (sequencer -> tester).
// Modports: master (tester side), slave (sequencer side).
interface sim_check_sequencer_if #(
  parameter int N_CHAN = 4,
  parameter int CNT_W  = 16
);
  localparam int FC_W = sim_check_pkg::fail_chan_w(N_CHAN);

  logic              start;
  logic [N_CHAN-1:0] chk_valid;
  logic [N_CHAN-1:0] chk_pass;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic              fail_valid;
  logic [FC_W-1:0]   fail_chan;
  logic [CNT_W-1:0]  cycle_cnt;

  modport master (
    output start, chk_valid, chk_pass,
    input  busy, done, pass, timeout, fail_valid, fail_chan, cycle_cnt
  );

  modport slave (
    input  start, chk_valid, chk_pass,
    output busy, done, pass, timeout, fail_valid, fail_chan, cycle_cnt
  );
endinterface

// File: rtl/sim_check_sequencer_tally.sv
// rtl/sim_check_sequencer_tally.sv - per-channel saturating pass counter
// Ports: clock, reset (async, active high), clr_i (clear at run start),
// inc_i (one valid pass this cycle), met_o (MIN_CHECKS reached, counting this cycle's inc_i).
module sim_check_chan_tally
  import sim_check_pkg::*;
#(
  parameter int MIN_CHECKS = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic met_o
);

  localparam logic [TALLY_W-1:0] MIN_V  = TALLY_W'(MIN_CHECKS);
  localparam logic [TALLY_W-1:0] MIN_M1 = TALLY_W'(MIN_CHECKS - 1);

  logic [TALLY_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != MIN_V)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Looks ahead by this cycle's pass so the sequencer can decide on the same edge.
  assign met_o = (cnt_q == MIN_V) || (inc_i && (cnt_q == MIN_M1));

endmodule

// File: rtl/sim_check_sequencer.sv
// rtl/sim_check_sequencer.sv - run/decide/drain/done controller for multi-channel checker benches
// Ports: clock, reset (async, active high), bus (sim_check_sequencer_if.slave).
// Optional: TESTER_FINISH_EN (with SYNTHESIS undefined) prints the result and calls
// $finish when DONE is entered; STOP_COND, if defined, further gates the $finish.
module sim_check_sequencer
  import sim_check_pkg::*;
#(
  parameter int N_CHAN       = 4,
  parameter int MIN_CHECKS   = 1,
  parameter int TIMEOUT      = 1000,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                  clock,
  input logic                  reset,
  sim_check_sequencer_if.slave bus
);

  localparam int                 FC_W       = fail_chan_w(N_CHAN);
  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               timeout_q;
  logic               fail_valid_q;
  logic [FC_W-1:0]    fail_chan_q;
  logic [CNT_W-1:0]   cycle_cnt_q;
  logic [DRAIN_W-1:0] drain_q;

  logic              in_run;
  logic              tally_clr;
  logic [N_CHAN-1:0] fail_vec;
  logic [N_CHAN-1:0] pass_vec;
  logic [N_CHAN-1:0] met;
  logic [FC_W-1:0]   fail_idx;
  logic              any_fail;
  logic              all_met;
  logic              to_hit;

  // Check inputs only count while running; outside RUN they are masked off.
  assign in_run    = (state_q == RUN);
  assign tally_clr = (state_q == IDLE) && bus.start;
  assign fail_vec  = bus.chk_valid & ~bus.chk_pass & {N_CHAN{in_run}};
  assign pass_vec  = bus.chk_valid &  bus.chk_pass & {N_CHAN{in_run}};
  assign any_fail  = |fail_vec;
  assign all_met   = &met;
  assign to_hit    = (cycle_cnt_q == TO_LAST);

  // Scan downward so the lowest failing index wins.
  always_comb begin
    fail_idx = '0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (fail_vec[i]) fail_idx = FC_W'(i);
    end
  end

  for (genvar g = 0; g < N_CHAN; g++) begin : g_tally
    sim_check_chan_tally #(
      .MIN_CHECKS(MIN_CHECKS)
    ) u_tally (
      .clock(clock),
      .reset(reset),
      .clr_i(tally_clr),
      .inc_i(pass_vec[g]),
      .met_o(met[g])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_chan_q  <= '0;
      cycle_cnt_q  <= '0;
      drain_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          cycle_cnt_q <= cycle_cnt_q + 1'b1;
          // Priority: fail, then completion, then timeout.
          if (any_fail || all_met || to_hit) begin
            fail_valid_q <= any_fail;
            fail_chan_q  <= any_fail ? fail_idx : '0;
            pass_q       <= !any_fail && all_met;
            timeout_q    <= !any_fail && !all_met;
            if (DRAIN_CYCLES == 0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
              drain_q <= DRAIN_LAST;
            end
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.timeout    = timeout_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_chan  = fail_chan_q;
  assign bus.cycle_cnt  = cycle_cnt_q;

`ifdef TESTER_FINISH_EN
`ifndef SYNTHESIS
`ifdef STOP_COND
  logic stop_cond = 1'b1;
`endif
  // done_q only rises on the clock edge entering DONE, after results are registered.
  always @(posedge done_q) begin
    result_e res;
    res = pass_q ? PASS : (fail_valid_q ? FAIL : (timeout_q ? TIMEOUT : NONE));
    $display("sim_check_sequencer: result=%s fail_chan=%0d cycle_cnt=%0d",
             res.name(), fail_chan_q, cycle_cnt_q);
`ifdef STOP_COND
    if (stop_cond) $finish;
`else
    $finish;
`endif
  end
`endif
`endif

endmodule

// File: tb/tb_sim_check_sequencer.sv
// tb/tb_sim_check_sequencer.sv - directed self-checking bench for sim_check_sequencer
module tb_sim_check_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [4:0] st;  // {busy, done, pass, timeout, fail_valid}

  always #5 clock = ~clock;

  sim_check_sequencer_if #(.N_CHAN(4), .CNT_W(16)) if0 ();
  sim_check_sequencer_if #(.N_CHAN(4), .CNT_W(16)) if1 ();
  sim_check_sequencer_if #(.N_CHAN(4), .CNT_W(16)) if2 ();

  // Defaults.
  sim_check_sequencer #(.N_CHAN(4), .MIN_CHECKS(1), .TIMEOUT(1000), .DRAIN_CYCLES(2), .CNT_W(16))
    u0 (.clock(clock), .reset(reset), .bus(if0));
  // Short timeout.
  sim_check_sequencer #(.N_CHAN(4), .MIN_CHECKS(1), .TIMEOUT(10), .DRAIN_CYCLES(2), .CNT_W(16))
    u1 (.clock(clock), .reset(reset), .bus(if1));
  // Three checks per channel, no drain.
  sim_check_sequencer #(.N_CHAN(4), .MIN_CHECKS(3), .TIMEOUT(50), .DRAIN_CYCLES(0), .CNT_W(16))
    u2 (.clock(clock), .reset(reset), .bus(if2));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    st = {if0.busy, if0.done, if0.pass, if0.timeout, if0.fail_valid};
    n_total++;
    if (st !== 5'b00000 || if0.cycle_cnt !== 16'd0 || if0.fail_chan !== 2'd0)
      $display("FAIL reset_u0 status=%b cnt=%0d chan=%0d expected 00000/0/0", st, if0.cycle_cnt, if0.fail_chan);
    else n_pass++;
    st = {if1.busy, if1.done, if1.pass, if1.timeout, if1.fail_valid}
       | {if2.busy, if2.done, if2.pass, if2.timeout, if2.fail_valid};
    n_total++;
    if (st !== 5'b00000) $display("FAIL reset_u1u2 status=%b expected 00000", st);
    else n_pass++;
    // Failing checks while idle must be ignored.
    if0.chk_valid = 4'hF; if0.chk_pass = 4'h0;
    tick(); tick();
    if0.chk_valid = 4'h0;
    st = {if0.busy, if0.done, if0.pass, if0.timeout, if0.fail_valid};
    n_total++;
    if (st !== 5'b00000 || if0.cycle_cnt !== 16'd0)
      $display("FAIL idle_ignore status=%b cnt=%0d expected 00000/0", st, if0.cycle_cnt);
    else n_pass++;
    // Start held only while reset is asserted is not honoured.
    reset = 1'b1; if0.start = 1'b1;
    tick();
    reset = 1'b0; if0.start = 1'b0;
    tick();
    n_total++;
    if (if0.busy !== 1'b0) $display("FAIL start_in_reset busy=%b expected 0", if0.busy);
    else n_pass++;
  endtask

  task automatic test_pass_default();
    do_reset();
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    n_total++;
    if (if0.busy !== 1'b1 || if0.cycle_cnt !== 16'd0)
      $display("FAIL start_busy busy=%b cnt=%0d expected 1/0", if0.busy, if0.cycle_cnt);
    else n_pass++;
    tick(); tick();
    if0.chk_valid = 4'hF; if0.chk_pass = 4'hF;
    tick();
    if0.chk_valid = 4'h0; if0.chk_pass = 4'h0;
    st = {if0.busy, if0.done, if0.pass, if0.timeout, if0.fail_valid};
    n_total++;
    if (st !== 5'b10100 || if0.cycle_cnt !== 16'd3)
      $display("FAIL pass_decide status=%b cnt=%0d expected 10100/3", st, if0.cycle_cnt);
    else n_pass++;
    tick();
    n_total++;
    if (if0.done !== 1'b0) $display("FAIL pass_drain done=%b expected 0", if0.done);
    else n_pass++;
    tick();
    st = {if0.busy, if0.done, if0.pass, if0.timeout, if0.fail_valid};
    n_total++;
    if (st !== 5'b01100 || if0.cycle_cnt !== 16'd3)
      $display("FAIL pass_done status=%b cnt=%0d expected 01100/3", st, if0.cycle_cnt);
    else n_pass++;
  endtask

  task automatic test_fail_lowest();
    do_reset();
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    if0.chk_valid = 4'b0011; if0.chk_pass = 4'b0011;
    tick();
    if0.chk_valid = 4'h0; if0.chk_pass = 4'h0;
    tick(); tick(); tick();
    st = {if0.busy, if0.done, if0.pass, if0.timeout, if0.fail_valid};
    n_total++;
    if (st !== 5'b10000 || if0.cycle_cnt !== 16'd4)
      $display("FAIL fail_prerun status=%b cnt=%0d expected 10000/4", st, if0.cycle_cnt);
    else n_pass++;
    if0.chk_valid = 4'b1101; if0.chk_pass = 4'b0001;
    tick();
    if0.chk_valid = 4'h0; if0.chk_pass = 4'h0;
    st = {if0.busy, if0.done, if0.pass, if0.timeout, if0.fail_valid};
    n_total++;
    if (st !== 5'b10001 || if0.fail_chan !== 2'd2 || if0.cycle_cnt !== 16'd5)
      $display("FAIL fail_decide status=%b chan=%0d cnt=%0d expected 10001/2/5", st, if0.fail_chan, if0.cycle_cnt);
    else n_pass++;
    tick(); tick();
    st = {if0.busy, if0.done, if0.pass, if0.timeout, if0.fail_valid};
    n_total++;
    if (st !== 5'b01001 || if0.fail_chan !== 2'd2 || if0.cycle_cnt !== 16'd5)
      $display("FAIL fail_done status=%b chan=%0d cnt=%0d expected 01001/2/5", st, if0.fail_chan, if0.cycle_cnt);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    repeat (9) tick();
    st = {if1.busy, if1.done, if1.pass, if1.timeout, if1.fail_valid};
    n_total++;
    if (st !== 5'b10000 || if1.cycle_cnt !== 16'd9)
      $display("FAIL to_before status=%b cnt=%0d expected 10000/9", st, if1.cycle_cnt);
    else n_pass++;
    tick();
    st = {if1.busy, if1.done, if1.pass, if1.timeout, if1.fail_valid};
    n_total++;
    if (st !== 5'b10010 || if1.cycle_cnt !== 16'd10)
      $display("FAIL to_decide status=%b cnt=%0d expected 10010/10", st, if1.cycle_cnt);
    else n_pass++;
    tick(); tick();
    st = {if1.busy, if1.done, if1.pass, if1.timeout, if1.fail_valid};
    n_total++;
    if (st !== 5'b01010 || if1.cycle_cnt !== 16'd10)
      $display("FAIL to_done status=%b cnt=%0d expected 01010/10", st, if1.cycle_cnt);
    else n_pass++;
  endtask

  task automatic test_fail_beats_pass();
    do_reset();
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    if2.chk_valid = 4'hF; if2.chk_pass = 4'hF;
    tick(); tick();
    if2.chk_valid = 4'b0111; if2.chk_pass = 4'b0111;
    tick();
    if2.chk_valid = 4'h0; if2.chk_pass = 4'h0;
    st = {if2.busy, if2.done, if2.pass, if2.timeout, if2.fail_valid};
    n_total++;
    if (st !== 5'b10000 || if2.cycle_cnt !== 16'd3)
      $display("FAIL min3_partial status=%b cnt=%0d expected 10000/3", st, if2.cycle_cnt);
    else n_pass++;
    // Channel 3 supplies its last needed pass while channel 1 fails.
    if2.chk_valid = 4'b1010; if2.chk_pass = 4'b1000;
    tick();
    if2.chk_valid = 4'h0; if2.chk_pass = 4'h0;
    st = {if2.busy, if2.done, if2.pass, if2.timeout, if2.fail_valid};
    n_total++;
    if (st !== 5'b01001 || if2.fail_chan !== 2'd1 || if2.cycle_cnt !== 16'd4)
      $display("FAIL fail_wins status=%b chan=%0d cnt=%0d expected 01001/1/4", st, if2.fail_chan, if2.cycle_cnt);
    else n_pass++;
  endtask

  task automatic test_min_pass_drain0();
    do_reset();
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    if2.chk_valid = 4'hF; if2.chk_pass = 4'hF;
    tick(); tick();
    st = {if2.busy, if2.done, if2.pass, if2.timeout, if2.fail_valid};
    n_total++;
    if (st !== 5'b10000) $display("FAIL min3_two status=%b expected 10000", st);
    else n_pass++;
    tick();
    if2.chk_valid = 4'h0; if2.chk_pass = 4'h0;
    st = {if2.busy, if2.done, if2.pass, if2.timeout, if2.fail_valid};
    n_total++;
    if (st !== 5'b01100 || if2.cycle_cnt !== 16'd3)
      $display("FAIL drain0_done status=%b cnt=%0d expected 01100/3", st, if2.cycle_cnt);
    else n_pass++;
    // Start in DONE is ignored.
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    tick(); tick();
    st = {if2.busy, if2.done, if2.pass, if2.timeout, if2.fail_valid};
    n_total++;
    if (st !== 5'b01100 || if2.cycle_cnt !== 16'd3)
      $display("FAIL done_start status=%b cnt=%0d expected 01100/3", st, if2.cycle_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    if0.chk_valid = 4'hF; if0.chk_pass = 4'hF;
    tick();
    if0.chk_valid = 4'h0; if0.chk_pass = 4'h0;
    st = {if0.busy, if0.done, if0.pass, if0.timeout, if0.fail_valid};
    n_total++;
    if (st !== 5'b10100 || if0.cycle_cnt !== 16'd1)
      $display("FAIL drain_enter status=%b cnt=%0d expected 10100/1", st, if0.cycle_cnt);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    st = {if0.busy, if0.done, if0.pass, if0.timeout, if0.fail_valid};
    n_total++;
    if (st !== 5'b00000 || if0.cycle_cnt !== 16'd0)
      $display("FAIL async_reset status=%b cnt=%0d expected 00000/0", st, if0.cycle_cnt);
    else n_pass++;
    tick();
    reset = 1'b0;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    if0.chk_valid = 4'b0001; if0.chk_pass = 4'b0000;
    tick();
    if0.chk_valid = 4'h0;
    tick(); tick();
    st = {if0.busy, if0.done, if0.pass, if0.timeout, if0.fail_valid};
    n_total++;
    if (st !== 5'b01001 || if0.fail_chan !== 2'd0 || if0.cycle_cnt !== 16'd1)
      $display("FAIL rerun status=%b chan=%0d cnt=%0d expected 01001/0/1", st, if0.fail_chan, if0.cycle_cnt);
    else n_pass++;
  endtask

  initial begin
    if0.start = 1'b0; if0.chk_valid = 4'h0; if0.chk_pass = 4'h0;
    if1.start = 1'b0; if1.chk_valid = 4'h0; if1.chk_pass = 4'h0;
    if2.start = 1'b0; if2.chk_valid = 4'h0; if2.chk_pass = 4'h0;
    test_reset();
    test_pass_default();
    test_fail_lowest();
    test_timeout();
    test_fail_beats_pass();
    test_min_pass_drain0();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/sim_check_sequencer.md
# sim_check_sequencer

Parametrised simulation-harness controller for multi-channel checker benches. After reset it waits for `start`, counts cycles while per-channel check results arrive, then decides pass, fail or timeout, drains for a fixed number of cycles, and holds a sticky `done`. It sits at the top of a tester wrapper, between the DUT-side checkers and the simulation finish logic, replacing single-shot "finish after reset" testers.

## Interface
- `N_CHAN`, default 4: number of check channels (1..32).
- `MIN_CHECKS`, default 1: passing checks each channel must report before overall pass (1..255).
- `TIMEOUT`, default 1000: RUN cycles allowed before timeout (≥1, < 2^CNT_W).
- `DRAIN_CYCLES`, default 2: cycles spent in DRAIN after the decision (0..255).
- `CNT_W`, default 16: width of the cycle counter.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a run; honoured only in IDLE.
- `chk_valid` in N_CHAN: channel i reports a check result this cycle.
- `chk_pass` in N_CHAN: result for channel i; meaningful only when `chk_valid[i]` is high.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: high in DONE; sticky until reset.
- `pass` out 1: valid with `done`; high only when every channel reached MIN_CHECKS with no failure.
- `timeout` out 1: valid with `done`; high when the run ended by timeout.
- `fail_valid` out 1: set when a channel failure ended the run.
- `fail_chan` out max(1,$clog2(N_CHAN)): lowest failing channel index in the deciding cycle.
- `cycle_cnt` out CNT_W: number of RUN cycles, including the deciding cycle.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset forces IDLE and clears all outputs, counters and per-channel tallies to 0.
- IDLE → RUN on `start`. While in IDLE, `chk_*` inputs are ignored.
- RUN, evaluated once per cycle, in this priority order:
  1. Any `chk_valid[i] & ~chk_pass[i]`: fail. Set `fail_valid` and set `fail_chan` to the lowest such i.
  2. Otherwise, all channel tallies (including this cycle's passes) ≥ MIN_CHECKS: pass.
  3. Otherwise, `cycle_cnt` == TIMEOUT-1: timeout.
  4. Otherwise, stay in RUN.
- On a decision, go to DRAIN, or to DONE directly if DRAIN_CYCLES = 0.
- Per-channel tally increments on each valid pass and saturates at MIN_CHECKS.
- DRAIN: lasts exactly DRAIN_CYCLES cycles, then goes to DONE. Inputs are ignored.
- DONE: terminal until reset. `start` is ignored.
- `pass`, `timeout`, `fail_valid` and `fail_chan` are registered at the decision edge and held. They are mutually exclusive: `pass` XOR `timeout` XOR `fail_valid`.
- `cycle_cnt` increments on every RUN cycle, including the deciding one, and is frozen afterwards. A timeout run therefore ends with `cycle_cnt` = TIMEOUT.
- Reset asserted mid-run (RUN or DRAIN) returns to IDLE immediately and asynchronously. No result is retained.

## Timing
- `start` sampled at edge k: `busy` is high after edge k. The first RUN-sampled inputs are at edge k+1.
- Decision at edge d: `done` rises after edge d + DRAIN_CYCLES. With DRAIN_CYCLES = 0, `done` rises after edge d.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Simultaneous events in the same cycle: a fail beats completion, which beats timeout. `start` arriving in the same cycle as reset deassertion is not honoured; reset wins.

## Configuration
- `TESTER_FINISH_EN`: when defined, and `SYNTHESIS` is not defined, the block does the following on the edge entering DONE:
  - issues `$display` with the result, `fail_chan` and `cycle_cnt`;
  - then calls `$finish`.
- If `STOP_COND` is also defined, the finish is further gated by it.
- Without `TESTER_FINISH_EN`: no simulation side effects. The outputs alone report the result.

## Structure
- Shared package `sim_check_pkg`:
  - state typedef: IDLE, RUN, DRAIN, DONE;
  - result typedef: NONE, PASS, FAIL, TIMEOUT;
  - function computing the `fail_chan` width.
- Sub-module `sim_check_chan_tally`: one instance per channel. Saturating counter with an async reset, a clear on `start`, and a `met` output.

## Test plan
- Defaults. Pulse `start`, then drive all 4 channels valid and passing on RUN cycle 3 → pass=1, timeout=0, fail_valid=0, cycle_cnt=3, `done` 2 cycles after the decision.
- Channels 2 and 3 fail in the same cycle (RUN cycle 5) → fail_valid=1, fail_chan=2, pass=0, cycle_cnt=5.
- No checks with TIMEOUT=10 → timeout=1, cycle_cnt=10, `done` after edge 12 past start+1.
- Fail and last-needed pass in the same cycle → fail wins; MIN_CHECKS=3 requires three passes per channel before pass.
- Reset asserted during DRAIN → all outputs 0 at once. A new `start` runs a fresh, independent test.
- DRAIN_CYCLES=0 → `done` the cycle after the decision. `start` pulses in DONE are ignored.
